// File: rtl/jk_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : jk_seq_ctrl_if
//  Description : Command handshake bundle for jk_seq_ctrl. The host drives
//                valid/op/arg/cnt; the sequencer returns ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface jk_seq_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;
    logic [CNT_W-1:0] cmd_cnt;

    modport master (output cmd_valid, cmd_op, cmd_arg, cmd_cnt, input  cmd_ready);
    modport slave  (input  cmd_valid, cmd_op, cmd_arg, cmd_cnt, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/jk_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : jk_seq_ctrl
//  Description : Command-driven sequencer producing registered J/K patterns
//                for a bank of JK flip-flops: masked clear/set/toggle, load,
//                and multi-step synchronous up (optionally down) counting
//                using Q feedback. Each count step takes two cycles (drive,
//                then settle) so the next pattern sees settled Q.
//                Optional feature macro: JK_SEQ_DOWN_EN (enables opcode 6).
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    jk_seq_ctrl_if.slave     cmd,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam logic [2:0] c_OP_NOP    = 3'd0;
    localparam logic [2:0] c_OP_CLEAR  = 3'd1;
    localparam logic [2:0] c_OP_SET    = 3'd2;
    localparam logic [2:0] c_OP_TOGGLE = 3'd3;
    localparam logic [2:0] c_OP_LOAD   = 3'd4;
    localparam logic [2:0] c_OP_UP     = 3'd5;
`ifdef JK_SEQ_DOWN_EN
    localparam logic [2:0] c_OP_DOWN   = 3'd6;
`endif

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DRIVE = 2'd1;
    localparam logic [1:0] c_ST_CDRV  = 2'd2;
    localparam logic [1:0] c_ST_CSET  = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = 1;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             r_done;
    logic             r_err;
    logic [CNT_W-1:0] r_rem;

    logic [WIDTH-1:0] w_single_j;
    logic [WIDTH-1:0] w_single_k;
    logic             w_is_single;
    logic             w_is_count;
    logic [WIDTH-1:0] w_up_t;
    logic [WIDTH-1:0] w_cnt_t;
    logic             w_unused_msb;

    assign cmd.cmd_ready = (r_state == c_ST_IDLE);
    assign busy          = (r_state != c_ST_IDLE);
    assign j_out         = r_j;
    assign k_out         = r_k;
    assign done          = r_done;
    assign err           = r_err;

    // The top Q bit never feeds a carry/borrow into any cell.
    assign w_unused_msb  = q_in[WIDTH-1];

    // Up-count toggle mask: a cell toggles when every lower cell is 1.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_up_pat
            if (gi == 0) begin : g_lsb
                assign w_up_t[gi] = 1'b1;
            end else begin : g_upper
                assign w_up_t[gi] = &q_in[gi-1:0];
            end
        end
    endgenerate

`ifdef JK_SEQ_DOWN_EN
    logic [WIDTH-1:0] w_dn_t;
    logic             w_cmd_down;
    logic             r_down;

    // Down-count toggle mask: a cell toggles when every lower cell is 0.
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_dn_pat
            if (gi == 0) begin : g_lsb
                assign w_dn_t[gi] = 1'b1;
            end else begin : g_upper
                assign w_dn_t[gi] = &(~q_in[gi-1:0]);
            end
        end
    endgenerate

    assign w_cmd_down = (cmd.cmd_op == c_OP_DOWN);
    assign w_is_count = (cmd.cmd_op == c_OP_UP) || w_cmd_down;
    // In IDLE the direction comes from the incoming opcode, later from the latch.
    assign w_cnt_t    = ((r_state == c_ST_IDLE) ? w_cmd_down : r_down) ? w_dn_t : w_up_t;

    // Remember the count direction for the remaining steps of the command.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_down <= 1'b0;
        end else if (cmd.cmd_valid && (r_state == c_ST_IDLE)) begin
            r_down <= w_cmd_down;
        end
    end
`else
    assign w_is_count = (cmd.cmd_op == c_OP_UP);
    assign w_cnt_t    = w_up_t;
`endif

    // Decode the single-shot J/K pattern for the presented opcode.
    always_comb begin
        w_single_j  = '0;
        w_single_k  = '0;
        w_is_single = 1'b1;
        case (cmd.cmd_op)
            c_OP_CLEAR:  begin w_single_k = cmd.cmd_arg; end
            c_OP_SET:    begin w_single_j = cmd.cmd_arg; end
            c_OP_TOGGLE: begin w_single_j = cmd.cmd_arg; w_single_k = cmd.cmd_arg; end
            c_OP_LOAD:   begin w_single_j = cmd.cmd_arg; w_single_k = ~cmd.cmd_arg; end
            default:     begin w_is_single = 1'b0; end
        endcase
    end

    // Sequencer state, registered J/K drive, step counter and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_j     <= '0;
            r_k     <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rem   <= c_CNT_ZERO;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_j    <= '0;
            r_k    <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        if (w_is_single) begin
                            r_state <= c_ST_DRIVE;
                            r_j     <= w_single_j;
                            r_k     <= w_single_k;
                        end else if (w_is_count && (cmd.cmd_cnt != c_CNT_ZERO)) begin
                            r_state <= c_ST_CDRV;
                            r_rem   <= cmd.cmd_cnt;
                            r_j     <= w_cnt_t;
                            r_k     <= w_cnt_t;
                        end else if (w_is_count || (cmd.cmd_op == c_OP_NOP)) begin
                            r_done  <= 1'b1;
                        end else begin
                            r_err   <= 1'b1;
                        end
                    end
                end
                c_ST_DRIVE: begin
                    r_state <= c_ST_IDLE;
                    r_done  <= 1'b1;
                end
                c_ST_CDRV: begin
                    r_state <= c_ST_CSET;
                    r_rem   <= r_rem - c_CNT_ONE;
                end
                c_ST_CSET: begin
                    if (r_rem != c_CNT_ZERO) begin
                        r_state <= c_ST_CDRV;
                        r_j     <= w_cnt_t;
                        r_k     <= w_cnt_t;
                    end else begin
                        r_state <= c_ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_jk_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_seq_ctrl
//  Description : Self-checking bench for jk_seq_ctrl with a JK bank model and
//                an arithmetic reference for the expected bank value.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_seq_ctrl;
    localparam int W  = 4;
    localparam int CW = 8;
`ifdef JK_SEQ_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] q   = '0;
    logic [W-1:0] j_out;
    logic [W-1:0] k_out;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] mq  = '0;
    int           total = 0;
    int           bad   = 0;

    always #5 clk = ~clk;

    jk_seq_ctrl_if #(.WIDTH(W), .CNT_W(CW)) cif ();

    jk_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .cmd   (cif),
        .q_in  (q),
        .j_out (j_out),
        .k_out (k_out),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    // JK flip-flop bank driven by the sequencer.
    always @(posedge clk) begin
        for (int i = 0; i < W; i++) begin
            case ({j_out[i], k_out[i]})
                2'b10:   q[i] <= 1'b1;
                2'b01:   q[i] <= 1'b0;
                2'b11:   q[i] <= ~q[i];
                default: q[i] <= q[i];
            endcase
        end
    end

    function automatic logic [W-1:0] next_q(input logic [2:0] op, input logic [W-1:0] arg,
                                            input logic [W-1:0] cur);
        case (op)
            3'd1:    return cur & ~arg;
            3'd2:    return cur | arg;
            3'd3:    return cur ^ arg;
            3'd4:    return arg;
            default: return cur;
        endcase
    endfunction

    function automatic logic [W-1:0] exp_j(input logic [2:0] op, input logic [W-1:0] arg);
        return (op >= 3'd2 && op <= 3'd4) ? arg : '0;
    endfunction

    function automatic logic [W-1:0] exp_k(input logic [2:0] op, input logic [W-1:0] arg);
        case (op)
            3'd1, 3'd3: return arg;
            3'd4:       return ~arg;
            default:    return '0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one command for exactly one edge; leaves the bench just after edge A.
    task automatic send(input logic [2:0] op, input logic [W-1:0] arg, input logic [CW-1:0] cnt);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_arg   = arg;
        cif.cmd_cnt   = cnt;
        step();
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 3'($urandom);
        cif.cmd_arg   = W'($urandom);
        cif.cmd_cnt   = CW'($urandom);
    endtask

    task automatic test_reset();
        step();
        step();
        total++;
        if ({j_out, k_out, busy, done, err} !== '0)
            begin bad++; $display("FAIL reset_outputs: got j=%h k=%h b=%b d=%b e=%b want all 0", j_out, k_out, busy, done, err); end
        rst = 1'b0;
        step();
        total++;
        if (cif.cmd_ready !== 1'b1)
            begin bad++; $display("FAIL reset_ready: got %b want 1", cif.cmd_ready); end
        // Abort an UP count after its first step has landed.
        send(3'd5, '0, 8'd5);
        step();
        mq = mq + 1'b1;
        rst = 1'b1;
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 3'd2;
        cif.cmd_arg   = 4'hF;
        for (int c = 0; c < 2; c++) begin
            step();
            total++;
            if (j_out !== '0 || k_out !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
                begin bad++; $display("FAIL reset_abort c=%0d: got j=%h k=%h b=%b d=%b e=%b want 0", c, j_out, k_out, busy, done, err); end
        end
        cif.cmd_valid = 1'b0;
        rst = 1'b0;
        step();
        total++;
        if (cif.cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || q !== mq)
            begin bad++; $display("FAIL reset_release: got rdy=%b d=%b b=%b q=%h want 1 0 0 %h", cif.cmd_ready, done, busy, q, mq); end
    endtask

    task automatic test_set_toggle();
        send(3'd4, 4'b0000, '0);
        step();
        mq = 4'b0000;
        send(3'd2, 4'b1010, '0);
        total++;
        if (j_out !== 4'b1010 || k_out !== 4'b0000 || busy !== 1'b1 || cif.cmd_ready !== 1'b0)
            begin bad++; $display("FAIL set_drive: got j=%h k=%h b=%b r=%b want j=a k=0 b=1 r=0", j_out, k_out, busy, cif.cmd_ready); end
        step();
        mq = 4'b1010;
        total++;
        if (done !== 1'b1 || q !== mq || j_out !== '0 || k_out !== '0)
            begin bad++; $display("FAIL set_done: got d=%b q=%h j=%h k=%h want 1 %h 0 0", done, q, j_out, k_out, mq); end
        send(3'd3, 4'b1111, '0);
        step();
        mq = 4'b0101;
        total++;
        if (q !== mq || done !== 1'b1)
            begin bad++; $display("FAIL toggle_result: got q=%h d=%b want %h 1", q, done, mq); end
    endtask

    task automatic test_load();
        send(3'd4, 4'b1001, '0);
        step();
        send(3'd4, 4'b0110, '0);
        total++;
        if (j_out !== 4'b0110 || k_out !== 4'b1001)
            begin bad++; $display("FAIL load_drive: got j=%h k=%h want 6 9", j_out, k_out); end
        step();
        mq = 4'b0110;
        total++;
        if (q !== mq || done !== 1'b1)
            begin bad++; $display("FAIL load_result: got q=%h d=%b want %h 1", q, done, mq); end
    endtask

    task automatic test_up_wrap();
        logic [W-1:0] seq [3];
        logic [W-1:0] nx;
        seq = '{4'b1111, 4'b0000, 4'b0001};
        send(3'd4, 4'b1110, '0);
        step();
        mq = 4'b1110;
        send(3'd5, '0, 8'd3);
        for (int s = 0; s < 3; s++) begin
            nx = mq + 1'b1;
            total++;
            if (j_out !== (mq ^ nx) || k_out !== (mq ^ nx) || done !== 1'b0)
                begin bad++; $display("FAIL up_cdrv s=%0d: got j=%h k=%h d=%b want %h", s, j_out, k_out, done, mq ^ nx); end
            step();
            mq = nx;
            total++;
            if (j_out !== '0 || k_out !== '0 || q !== seq[s] || done !== 1'b0 || busy !== 1'b1)
                begin bad++; $display("FAIL up_cset s=%0d: got j=%h k=%h q=%h d=%b want 0 0 %h 0", s, j_out, k_out, q, done, seq[s]); end
            step();
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0)
            begin bad++; $display("FAIL up_done: got d=%b b=%b want 1 0", done, busy); end
    endtask

    task automatic test_edge_ops();
        send(3'd0, 4'hF, '0);
        total++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("FAIL nop_done: got d=%b e=%b b=%b want 1 0 0", done, err, busy); end
        send(3'd5, 4'hF, 8'd0);
        total++;
        if (done !== 1'b1 || q !== mq || j_out !== '0)
            begin bad++; $display("FAIL up0_done: got d=%b q=%h j=%h want 1 %h 0", done, q, j_out, mq); end
        send(3'd7, 4'hF, 8'd4);
        total++;
        if (err !== 1'b1 || done !== 1'b0 || j_out !== '0 || k_out !== '0)
            begin bad++; $display("FAIL illegal_err: got e=%b d=%b j=%h k=%h want 1 0 0 0", err, done, j_out, k_out); end
        step();
        total++;
        if (err !== 1'b0 || q !== mq)
            begin bad++; $display("FAIL illegal_after: got e=%b q=%h want 0 %h", err, q, mq); end
        // Single-shot followed by an accept at A+2.
        send(3'd2, 4'b0001, '0);
        step();
        mq = mq | 4'b0001;
        send(3'd1, 4'b0001, '0);
        total++;
        if (k_out !== 4'b0001 || j_out !== '0 || busy !== 1'b1)
            begin bad++; $display("FAIL b2b_accept: got j=%h k=%h b=%b want 0 1 1", j_out, k_out, busy); end
        step();
        mq = mq & 4'b1110;
        total++;
        if (q !== mq || done !== 1'b1)
            begin bad++; $display("FAIL b2b_result: got q=%h d=%b want %h 1", q, done, mq); end
    endtask

    task automatic test_down();
        logic [W-1:0] want_q1;
        logic [W-1:0] want_q2;
        want_q1 = DOWN_EN ? 4'b1111 : 4'b0000;
        want_q2 = DOWN_EN ? 4'b1110 : 4'b0000;
        send(3'd4, 4'b0000, '0);
        step();
        send(3'd6, '0, 8'd2);
        total++;
        if (err !== !DOWN_EN || j_out !== want_q1 || k_out !== want_q1)
            begin bad++; $display("FAIL down_start: got e=%b j=%h k=%h want %b %h", err, j_out, k_out, !DOWN_EN, want_q1); end
        step();
        total++;
        if (q !== want_q1)
            begin bad++; $display("FAIL down_step1: got q=%h want %h", q, want_q1); end
        step();
        step();
        total++;
        if (q !== want_q2)
            begin bad++; $display("FAIL down_step2: got q=%h want %h", q, want_q2); end
        step();
        total++;
        if (done !== DOWN_EN || busy !== 1'b0)
            begin bad++; $display("FAIL down_done: got d=%b b=%b want %b 0", done, busy, DOWN_EN); end
        mq = want_q2;
    endtask

    task automatic test_random();
        logic [2:0]    op;
        logic [W-1:0]  arg;
        logic [CW-1:0] cnt;
        logic [W-1:0]  nx;
        logic          is_single;
        logic          is_cnt;
        for (int it = 0; it < 60; it++) begin
            op  = 3'($urandom_range(0, 7));
            arg = W'($urandom);
            cnt = CW'($urandom_range(0, 4));
            is_single = (op >= 3'd1) && (op <= 3'd4);
            is_cnt    = (op == 3'd5) || ((op == 3'd6) && DOWN_EN);
            if ($urandom_range(0, 3) == 0) step();
            send(op, arg, cnt);
            if (is_single) begin
                total++;
                if (j_out !== exp_j(op, arg) || k_out !== exp_k(op, arg) || busy !== 1'b1)
                    begin bad++; $display("FAIL rand_drive it=%0d op=%0d: got j=%h k=%h want j=%h k=%h", it, op, j_out, k_out, exp_j(op, arg), exp_k(op, arg)); end
                step();
                mq = next_q(op, arg, mq);
                total++;
                if (done !== 1'b1 || q !== mq || j_out !== '0 || k_out !== '0)
                    begin bad++; $display("FAIL rand_single it=%0d op=%0d: got d=%b q=%h want 1 %h", it, op, done, q, mq); end
            end else if (is_cnt && cnt != '0) begin
                for (int s = 0; s < int'(cnt); s++) begin
                    nx = (op == 3'd5) ? mq + 1'b1 : mq - 1'b1;
                    total++;
                    if (j_out !== (mq ^ nx) || k_out !== (mq ^ nx) || busy !== 1'b1 || done !== 1'b0)
                        begin bad++; $display("FAIL rand_cdrv it=%0d s=%0d: got j=%h k=%h want %h", it, s, j_out, k_out, mq ^ nx); end
                    step();
                    mq = nx;
                    total++;
                    if (j_out !== '0 || k_out !== '0 || q !== mq || done !== 1'b0)
                        begin bad++; $display("FAIL rand_cset it=%0d s=%0d: got j=%h k=%h q=%h want 0 0 %h", it, s, j_out, k_out, q, mq); end
                    step();
                end
                total++;
                if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0)
                    begin bad++; $display("FAIL rand_cdone it=%0d: got d=%b b=%b e=%b want 1 0 0", it, done, busy, err); end
            end else if (is_cnt || op == 3'd0) begin
                total++;
                if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || j_out !== '0)
                    begin bad++; $display("FAIL rand_nop it=%0d op=%0d: got d=%b e=%b want 1 0", it, op, done, err); end
            end else begin
                total++;
                if (err !== 1'b1 || done !== 1'b0 || j_out !== '0 || k_out !== '0)
                    begin bad++; $display("FAIL rand_illegal it=%0d op=%0d: got e=%b d=%b want 1 0", it, op, err, done); end
            end
        end
    endtask

    initial begin
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = '0;
        cif.cmd_arg   = '0;
        cif.cmd_cnt   = '0;
        #1;
        test_reset();
        test_set_toggle();
        test_load();
        test_up_wrap();
        test_edge_ops();
        test_down();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
